ni_packetizer: RTL



---
 rtl/ni_pkg.sv | 50 +++++
 rtl/ni_credit_counter.sv | 45 ++++
 rtl/ni_packetizer.sv | 115 +++++++++++
 3 files changed

// File: rtl/ni_pkg.sv
// Shared definitions for the NI transmit path: flit format, type codes,
// head-flit field layout and the packetizer state encoding.
package ni_pkg;

  localparam int FLIT_W    = 34;
  localparam int PAYLOAD_W = 32;
  localparam int COORD_W   = 2;
  localparam int LADDR_W   = 12;

  typedef logic [1:0] flit_type_t;

  localparam flit_type_t FLIT_NONE = 2'b00;
  localparam flit_type_t FLIT_HEAD = 2'b01;
  localparam flit_type_t FLIT_BODY = 2'b10;  // reserved; never emitted by this NI
  localparam flit_type_t FLIT_TAIL = 2'b11;

  // Head payload layout: {dest_x, dest_y, src_x, src_y, 12'h000, local_addr}
  localparam int HEAD_DEST_X_LSB = 30;
  localparam int HEAD_DEST_Y_LSB = 28;
  localparam int HEAD_SRC_X_LSB  = 26;
  localparam int HEAD_SRC_Y_LSB  = 24;
  localparam int HEAD_ADDR_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_HEAD  = 3'd3,
    ST_TAIL  = 3'd4
  } state_t;

  // Assemble a head payload from routing coordinates and the local address.
  function automatic logic [PAYLOAD_W-1:0] head_payload(
    input logic [COORD_W-1:0] dest_x,
    input logic [COORD_W-1:0] dest_y,
    input logic [COORD_W-1:0] src_x,
    input logic [COORD_W-1:0] src_y,
    input logic [LADDR_W-1:0] local_addr
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[HEAD_DEST_X_LSB +: COORD_W] = dest_x;
    p[HEAD_DEST_Y_LSB +: COORD_W] = dest_y;
    p[HEAD_SRC_X_LSB  +: COORD_W] = src_x;
    p[HEAD_SRC_Y_LSB  +: COORD_W] = src_y;
    p[HEAD_ADDR_LSB   +: LADDR_W] = local_addr;
    return p;
  endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Credit tracker for the local router input port: one credit per free buffer
// slot. Saturates at CREDITS and flags a sticky error on an excess return.
module ni_credit_counter
  import ni_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic aclk,
  input  logic reset,
  input  logic consume,
  input  logic credit_in,
  output logic avail,
  output logic credit_err
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count;

  // Update the free-slot count from sends and returns; flag over-returns.
  // NOTE: sequential state is written with <= so every register in the block
  // sees the pre-edge value of every other register.
  always_ff @(posedge aclk) begin
    if (reset) begin
      count      <= CNT_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({consume, credit_in})
        2'b10: begin
          if (count != '0) count <= count - 1'b1;
        end
        2'b01: begin
          if (count == CNT_MAX) credit_err <= 1'b1;
          else                  count      <= count + 1'b1;
        end
        default: ;  // idle, or a send and a return cancelling each other
      endcase
    end
  end

  // Stall decisions look only at the registered count.
  assign avail = (count != '0);

endmodule

// File: rtl/ni_packetizer.sv
// NI transmit stage: pops {awaddr, wdata} entries from the NI write FIFO and
// emits each as a head + tail flit pair toward the local router, under
// credit-based flow control. A reset mid-packet drops the entry in flight.
module ni_packetizer
  import ni_pkg::*;
#(
  parameter  int ADDRSIZE = 5,
  parameter  int NODE_X   = 0,
  parameter  int NODE_Y   = 0,
  parameter  int CREDITS  = 4,
  localparam int DSIZE    = 1 << ADDRSIZE,
  localparam int RSIZE    = DSIZE / 2
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DSIZE-1:0]  fifo_rd_data,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              credit_in,
  output logic              busy,
  output logic              credit_err
);

  localparam logic [COORD_W-1:0] SRC_X = COORD_W'(NODE_X);
  localparam logic [COORD_W-1:0] SRC_Y = COORD_W'(NODE_Y);

  state_t           state;
  logic [DSIZE-1:0] entry;
  logic [RSIZE-1:0] awaddr;
  logic [RSIZE-1:0] wdata;
  logic             avail;
  logic             consume;

  assign awaddr  = entry[DSIZE-1 -: RSIZE];
  assign wdata   = entry[RSIZE-1:0];
  assign consume = ((state == ST_HEAD) || (state == ST_TAIL)) && avail;

  ni_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .aclk       (aclk),
    .reset      (reset),
    .consume    (consume),
    .credit_in  (credit_in),
    .avail      (avail),
    .credit_err (credit_err)
  );

  // Capture the popped FIFO entry the cycle after the pop request.
  // NOTE: the entry register has no reset; it is always written in LOAD
  // before HEAD/TAIL read it, so its power-up content is never observed.
  always_ff @(posedge aclk) begin
    if (state == ST_LOAD) entry <= fifo_rd_data;
  end

  // Packet sequencer: fetch, load, then head and tail flits gated by credits.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state      <= ST_IDLE;
      fifo_rd_en <= 1'b0;
      flit_valid <= 1'b0;
      flit_out   <= '0;
      busy       <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      flit_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state      <= ST_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_FETCH: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          state <= ST_HEAD;
        end
        ST_HEAD: begin
          if (avail) begin
            flit_valid <= 1'b1;
            flit_out   <= {FLIT_HEAD,
                           head_payload(awaddr[RSIZE-1 -: COORD_W],
                                        awaddr[RSIZE-1-COORD_W -: COORD_W],
                                        SRC_X, SRC_Y,
                                        awaddr[LADDR_W-1:0])};
            state      <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (avail) begin
            flit_valid <= 1'b1;
            flit_out   <= {FLIT_TAIL, {(PAYLOAD_W-RSIZE){1'b0}}, wdata};
            if (!fifo_empty) begin
              state      <= ST_FETCH;
              fifo_rd_en <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
